// File: rtl/store_unit_pkg.sv
// Shared types and helpers for the coalescing store buffer.
// Entry fields are sized by the package widths; the buffer's width parameters default to them.
package store_unit_pkg;

    localparam int unsigned StBufByteW     = 8;
    localparam int unsigned StBufAddrWidth = 32;
    localparam int unsigned StBufDataBytes = 4;
    localparam int unsigned StBufOfs       = $clog2(StBufDataBytes);

    typedef struct packed {
        logic [StBufAddrWidth-StBufOfs-1:0] word_addr;
        logic [StBufByteW*StBufDataBytes-1:0] data;
        logic [StBufDataBytes-1:0] strobe;
    } st_buf_entry_t;

    typedef enum logic [0:0] {
        StIdle,
        StDrain
    } st_buf_drain_state_t;

    // Expand a byte strobe into a bit mask over the data word.
    function automatic logic [StBufByteW*StBufDataBytes-1:0] lane_mask(
        input logic [StBufDataBytes-1:0] strobe
    );
        logic [StBufByteW*StBufDataBytes-1:0] mask;
        for (int unsigned b = 0; b < StBufDataBytes; b++) begin
            mask[StBufByteW*b +: StBufByteW] = {StBufByteW{strobe[b]}};
        end
        return mask;
    endfunction

    function automatic logic [StBufByteW*StBufDataBytes-1:0] merge_lanes(
        input logic [StBufByteW*StBufDataBytes-1:0] old_data,
        input logic [StBufByteW*StBufDataBytes-1:0] new_data,
        input logic [StBufDataBytes-1:0]            strobe
    );
        logic [StBufByteW*StBufDataBytes-1:0] mask;
        mask = lane_mask(strobe);
        return (old_data & ~mask) | (new_data & mask);
    endfunction

endpackage

// File: rtl/store_forward_select.sv
// Per-lane youngest-match select over entries ordered oldest (index 0) to youngest.
module store_forward_select
    import store_unit_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WORD_WIDTH = 30,
    parameter int unsigned DATA_BYTES = 4
) (
    input  logic [WORD_WIDTH-1:0]            word_i   [DEPTH],
    input  logic [StBufByteW*DATA_BYTES-1:0] data_i   [DEPTH],
    input  logic [DATA_BYTES-1:0]            strobe_i [DEPTH],
    input  logic [DEPTH-1:0]                 valid_i,
    input  logic [WORD_WIDTH-1:0]            fwd_word_i,
    output logic [StBufByteW*DATA_BYTES-1:0] fwd_data_o,
    output logic [DATA_BYTES-1:0]            fwd_strobe_o
);

    // Later (younger) matches overwrite earlier ones lane by lane.
    always_comb begin
        fwd_data_o   = '0;
        fwd_strobe_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_i[i] && (word_i[i] == fwd_word_i)) begin
                for (int unsigned b = 0; b < DATA_BYTES; b++) begin
                    if (strobe_i[i][b]) begin
                        fwd_data_o[StBufByteW*b +: StBufByteW] =
                            data_i[i][StBufByteW*b +: StBufByteW];
                        fwd_strobe_o[b] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/coalescing_store_buffer.sv
// In-order byte-granular store buffer with load forwarding and drain fence.
// Define ST_BUF_MERGE_EN to coalesce same-word pushes into the youngest entry.
module coalescing_store_buffer
    import store_unit_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = StBufAddrWidth,
    parameter int unsigned DATA_BYTES = StBufDataBytes
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    push_valid_i,
    output logic                    push_ready_o,
    input  logic [ADDR_WIDTH-1:0]   push_address_i,
    input  logic [8*DATA_BYTES-1:0] push_data_i,
    input  logic [DATA_BYTES-1:0]   push_strobe_i,
    output logic                    pull_valid_o,
    input  logic                    pull_ready_i,
    output logic [ADDR_WIDTH-1:0]   pull_address_o,
    output logic [8*DATA_BYTES-1:0] pull_data_o,
    output logic [DATA_BYTES-1:0]   pull_strobe_o,
    input  logic [ADDR_WIDTH-1:0]   fwd_address_i,
    output logic [8*DATA_BYTES-1:0] fwd_data_o,
    output logic [DATA_BYTES-1:0]   fwd_strobe_o,
    output logic                    fwd_hit_o,
    output logic                    fwd_full_o,
    input  logic                    drain_i,
    output logic                    drained_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int unsigned Ofs   = $clog2(DATA_BYTES);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned WordW = ADDR_WIDTH - Ofs;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [PtrW:0]   cnt_t;

    localparam cnt_t DepthCnt = cnt_t'(DEPTH);

    st_buf_entry_t       entries_q [DEPTH];
    ptr_t                head_q, tail_q;
    cnt_t                count_q, count_d;
    cnt_t                fence_cnt_q, fence_load;
    st_buf_drain_state_t state_q;
    logic                drained_q;

    logic [WordW-1:0] push_word;
    logic [WordW-1:0] fwd_word;
    logic             merge_hit, push_fire, alloc, merge_fire, pop;

    assign push_word = push_address_i[ADDR_WIDTH-1:Ofs];
    assign fwd_word  = fwd_address_i[ADDR_WIDTH-1:Ofs];

    if (Ofs > 0) begin : g_unused_ofs
        logic unused_ofs_bits;
        assign unused_ofs_bits = ^{push_address_i[Ofs-1:0], fwd_address_i[Ofs-1:0]};
    end

    assign full_o       = (count_q == DepthCnt);
    assign empty_o      = (count_q == '0);
    assign pull_valid_o = !empty_o;
    assign pop          = pull_valid_o && pull_ready_i;

`ifdef ST_BUF_MERGE_EN
    ptr_t youngest;
    logic merge_lock_q;

    assign youngest = tail_q - ptr_t'(1);
    // count >= 2 keeps the merge target off the head entry, which may be popping.
    assign merge_hit = (count_q >= cnt_t'(2)) &&
                       (entries_q[youngest].word_addr == push_word) &&
                       !merge_lock_q && !drain_i;
`else
    assign merge_hit = 1'b0;
`endif

    assign push_ready_o = !full_o || merge_hit;
    assign push_fire    = push_valid_i && push_ready_o;
    assign alloc        = push_fire && !merge_hit;
    assign merge_fire   = push_fire && merge_hit;

    assign count_d    = count_q + cnt_t'(alloc) - cnt_t'(pop);
    assign fence_load = count_q - cnt_t'(pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc) tail_q <= tail_q + ptr_t'(1);
            if (pop) head_q <= head_q + ptr_t'(1);
            count_q <= count_d;
        end
    end

    // Entry payload carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            entries_q[tail_q] <= '{
                word_addr: push_word,
                data:      push_data_i & lane_mask(push_strobe_i),
                strobe:    push_strobe_i
            };
        end
`ifdef ST_BUF_MERGE_EN
        else if (merge_fire) begin
            entries_q[youngest].data <=
                merge_lanes(entries_q[youngest].data, push_data_i, push_strobe_i);
            entries_q[youngest].strobe <= entries_q[youngest].strobe | push_strobe_i;
        end
`endif
    end

`ifdef ST_BUF_MERGE_EN
    // A fence blocks merging into pre-fence entries until the next allocation.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            merge_lock_q <= 1'b0;
        end else if (alloc) begin
            merge_lock_q <= 1'b0;
        end else if (drain_i && (state_q == StIdle)) begin
            merge_lock_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            fence_cnt_q <= '0;
            drained_q   <= 1'b0;
        end else begin
            drained_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (drain_i) begin
                        if (fence_load == '0) begin
                            drained_q <= 1'b1;
                        end else begin
                            state_q     <= StDrain;
                            fence_cnt_q <= fence_load;
                        end
                    end
                end
                StDrain: begin
                    if (pop) begin
                        fence_cnt_q <= fence_cnt_q - cnt_t'(1);
                        if (fence_cnt_q == cnt_t'(1)) begin
                            drained_q <= 1'b1;
                            state_q   <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign drained_o      = drained_q;
    assign pull_address_o = ADDR_WIDTH'(entries_q[head_q].word_addr) << Ofs;
    assign pull_data_o    = entries_q[head_q].data;
    assign pull_strobe_o  = entries_q[head_q].strobe;

    logic [WordW-1:0]        ord_word   [DEPTH];
    logic [8*DATA_BYTES-1:0] ord_data   [DEPTH];
    logic [DATA_BYTES-1:0]   ord_strobe [DEPTH];
    logic [DEPTH-1:0]        ord_valid;

    // Rotate storage so index 0 is the head (oldest) entry.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ord_word[i]   = entries_q[head_q + ptr_t'(i)].word_addr;
            ord_data[i]   = entries_q[head_q + ptr_t'(i)].data;
            ord_strobe[i] = entries_q[head_q + ptr_t'(i)].strobe;
            ord_valid[i]  = (cnt_t'(i) < count_q);
        end
    end

    store_forward_select #(
        .DEPTH      (DEPTH),
        .WORD_WIDTH (WordW),
        .DATA_BYTES (DATA_BYTES)
    ) u_fwd_select (
        .word_i       (ord_word),
        .data_i       (ord_data),
        .strobe_i     (ord_strobe),
        .valid_i      (ord_valid),
        .fwd_word_i   (fwd_word),
        .fwd_data_o   (fwd_data_o),
        .fwd_strobe_o (fwd_strobe_o)
    );

    assign fwd_hit_o  = |fwd_strobe_o;
    assign fwd_full_o = &fwd_strobe_o;

endmodule

// File: tb/tb_coalescing_store_buffer.sv
// Directed bench for coalescing_store_buffer at DEPTH=4; merge expectations follow ST_BUF_MERGE_EN.
module tb_coalescing_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [31:0] push_address = '0;
    logic [31:0] push_data = '0;
    logic [3:0]  push_strobe = '0;
    logic        pull_valid;
    logic        pull_ready = 1'b0;
    logic [31:0] pull_address;
    logic [31:0] pull_data;
    logic [3:0]  pull_strobe;
    logic [31:0] fwd_address = '0;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_strobe;
    logic        fwd_hit;
    logic        fwd_full;
    logic        drain = 1'b0;
    logic        drained;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;

    coalescing_store_buffer #(
        .DEPTH      (4),
        .ADDR_WIDTH (32),
        .DATA_BYTES (4)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .push_valid_i   (push_valid),
        .push_ready_o   (push_ready),
        .push_address_i (push_address),
        .push_data_i    (push_data),
        .push_strobe_i  (push_strobe),
        .pull_valid_o   (pull_valid),
        .pull_ready_i   (pull_ready),
        .pull_address_o (pull_address),
        .pull_data_o    (pull_data),
        .pull_strobe_o  (pull_strobe),
        .fwd_address_i  (fwd_address),
        .fwd_data_o     (fwd_data),
        .fwd_strobe_o   (fwd_strobe),
        .fwd_hit_o      (fwd_hit),
        .fwd_full_o     (fwd_full),
        .drain_i        (drain),
        .drained_o      (drained),
        .full_o         (full),
        .empty_o        (empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        push_valid   = 1'b1;
        push_address = a;
        push_data    = d;
        push_strobe  = s;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        check({tag, "_valid"}, pull_valid, 1'b1);
        check({tag, "_addr"}, pull_address, a);
        check({tag, "_data"}, pull_data, d);
        check({tag, "_strb"}, pull_strobe, s);
        pull_ready = 1'b1;
        tick();
        pull_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        #12;
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_pull_valid", pull_valid, 1'b0);
        check("rst_push_ready", push_ready, 1'b1);
        check("rst_drained", drained, 1'b0);
        check("rst_fwd_strobe", fwd_strobe, 4'h0);
        check("rst_fwd_data", fwd_data, 32'h0);
        check("rst_fwd_hit", fwd_hit, 1'b0);
        check("rst_fwd_full", fwd_full, 1'b0);
        #5 rst_n = 1'b1;
        tick();

        // In-order push/pull
        push(32'h100, 32'hAABBCCDD, 4'b1111);
        push(32'h200, 32'h00000011, 4'b0001);
        check("t1_empty", empty, 1'b0);
        pop_check("t1_p0", 32'h100, 32'hAABBCCDD, 4'hF);
        pop_check("t1_p1", 32'h200, 32'h00000011, 4'h1);
        check("t1_empty_after", empty, 1'b1);
        check("t1_pull_valid_after", pull_valid, 1'b0);

        // Coalescing into the youngest entry
        push(32'h100, 32'h00000001, 4'b0001);
        push(32'h200, 32'h00000011, 4'b0001);
        push_valid   = 1'b1;
        push_address = 32'h202;
        push_data    = 32'h00220000;
        push_strobe  = 4'b0100;
        #1 check("t2_push_ready", push_ready, 1'b1);
        tick();
        push_valid = 1'b0;
        pop_check("t2_p0", 32'h100, 32'h00000001, 4'h1);
`ifdef ST_BUF_MERGE_EN
        pop_check("t2_p1", 32'h200, 32'h00220011, 4'h5);
`else
        pop_check("t2_p1", 32'h200, 32'h00000011, 4'h1);
        pop_check("t2_p2", 32'h200, 32'h00220000, 4'h4);
`endif
        check("t2_empty", empty, 1'b1);

        // Full buffer: merge still accepted, new word stalls
        push(32'h000, 32'h00000001, 4'b0001);
        push(32'h100, 32'h00000002, 4'b0001);
        push(32'h200, 32'h00000003, 4'b0001);
        push(32'h300, 32'h00000004, 4'b0001);
        check("t3_full", full, 1'b1);
        push_valid   = 1'b1;
        push_address = 32'h301;
        push_data    = 32'h0000AA00;
        push_strobe  = 4'b0010;
`ifdef ST_BUF_MERGE_EN
        #1 check("t3_merge_ready", push_ready, 1'b1);
`else
        #1 check("t3_merge_ready", push_ready, 1'b0);
`endif
        tick();
        push_valid = 1'b0;
        check("t3_full_held", full, 1'b1);
        push_valid   = 1'b1;
        push_address = 32'h400;
        push_data    = 32'h00000005;
        push_strobe  = 4'b0001;
        #1 check("t3_stall", push_ready, 1'b0);
        push_valid = 1'b0;
        pop_check("t3_p0", 32'h000, 32'h00000001, 4'h1);
        pop_check("t3_p1", 32'h100, 32'h00000002, 4'h1);
        pop_check("t3_p2", 32'h200, 32'h00000003, 4'h1);
`ifdef ST_BUF_MERGE_EN
        pop_check("t3_p3", 32'h300, 32'h0000AA04, 4'h3);
`else
        pop_check("t3_p3", 32'h300, 32'h00000004, 4'h1);
`endif
        check("t3_empty", empty, 1'b1);

        // Forwarding across two entries of the same word
        push(32'h100, 32'h000000FF, 4'b0001);
        drain = 1'b1;
        tick();
        drain = 1'b0;
        push(32'h100, 32'h0000EE00, 4'b0010);
        fwd_address = 32'h100;
        #1;
        check("t4_fwd_strobe", fwd_strobe, 4'b0011);
        check("t4_fwd_data", fwd_data, 32'h0000EEFF);
        check("t4_fwd_hit", fwd_hit, 1'b1);
        check("t4_fwd_full", fwd_full, 1'b0);
        fwd_address = 32'h103;
        #1 check("t4_fwd_low_bits", fwd_strobe, 4'b0011);
        fwd_address = 32'h104;
        #1;
        check("t4_fwd_miss_hit", fwd_hit, 1'b0);
        check("t4_fwd_miss_data", fwd_data, 32'h0);
        fwd_address = 32'h100;
        pop_check("t4_p0", 32'h100, 32'h000000FF, 4'h1);
        check("t4_drained", drained, 1'b1);
        check("t4_fwd_after_pop_strobe", fwd_strobe, 4'b0010);
        check("t4_fwd_after_pop_data", fwd_data, 32'h0000EE00);
        tick();
        check("t4_drained_low", drained, 1'b0);
        pop_check("t4_p1", 32'h100, 32'h0000EE00, 4'h2);
        check("t4_fwd_empty", fwd_hit, 1'b0);

        // Fence: post-drain push to tail word allocates; pulse after the 3rd pop
        push(32'h300, 32'h00000010, 4'b0001);
        push(32'h200, 32'h00000020, 4'b0001);
        push(32'h100, 32'h00000030, 4'b0001);
        drain = 1'b1;
        tick();
        drain = 1'b0;
        push_valid   = 1'b1;
        push_address = 32'h100;
        push_data    = 32'h0000BB00;
        push_strobe  = 4'b0010;
        #1 check("t5_push_ready", push_ready, 1'b1);
        tick();
        push_valid = 1'b0;
        check("t5_locked_alloc_full", full, 1'b1);
        pop_check("t5_p0", 32'h300, 32'h00000010, 4'h1);
        check("t5_drained_p0", drained, 1'b0);
        pop_check("t5_p1", 32'h200, 32'h00000020, 4'h1);
        check("t5_drained_p1", drained, 1'b0);
        pop_check("t5_p2", 32'h100, 32'h00000030, 4'h1);
        check("t5_drained_p2", drained, 1'b1);
        tick();
        check("t5_drained_pulse_end", drained, 1'b0);
        pop_check("t5_p3", 32'h100, 32'h0000BB00, 4'h2);
        check("t5_empty", empty, 1'b1);
        check("t5_drained_late", drained, 1'b0);

        // Drain of an empty buffer
        drain = 1'b1;
        tick();
        drain = 1'b0;
        check("t6_empty_drained", drained, 1'b1);
        tick();
        check("t6_empty_drained_low", drained, 1'b0);

        // Reset in the middle of a drain
        push(32'h500, 32'h00000050, 4'b0001);
        push(32'h600, 32'h00000060, 4'b0001);
        drain = 1'b1;
        tick();
        drain = 1'b0;
        check("t7_pre_valid", pull_valid, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("t7_rst_empty", empty, 1'b1);
        check("t7_rst_drained", drained, 1'b0);
        check("t7_rst_pull_valid", pull_valid, 1'b0);
        check("t7_rst_push_ready", push_ready, 1'b1);
        #2 rst_n = 1'b1;
        tick();
        push(32'h700, 32'h00000070, 4'b0001);
        pop_check("t7_p0", 32'h700, 32'h00000070, 4'h1);
        check("t7_post_empty", empty, 1'b1);
        check("t7_post_drained", drained, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coalescing_store_buffer.md
# coalescing_store_buffer

Parametrised, byte-granular store buffer between the store unit and the bus controller, sitting in the memory system. Accepts committed (non-speculative) stores with byte strobes, coalesces stores to the same word into the youngest entry, and drains entries in order to memory. Gives the load unit per-byte forwarding from the youngest matching bytes, and supports a drain/fence handshake that orders all earlier stores before later ones.

## Interface
- `DEPTH`, 8: entry count; power of two, ≥2.
- `ADDR_WIDTH`, 32: address bits.
- `DATA_BYTES`, 4: bytes per entry; power of two. `OFS = log2(DATA_BYTES)`.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `push_valid_i` in 1: store request.
- `push_ready_o` out 1: store accepted this cycle if high with `push_valid_i`.
- `push_address_i` in ADDR_WIDTH: byte address; low `OFS` bits ignored.
- `push_data_i` in 8·DATA_BYTES: lane-aligned store data.
- `push_strobe_i` in DATA_BYTES: byte enables; never all-zero.
- `pull_valid_o` out 1: head entry presented.
- `pull_ready_i` in 1: bus controller accepts head; pops it.
- `pull_address_o` out ADDR_WIDTH: head word address, low `OFS` bits zero.
- `pull_data_o` out 8·DATA_BYTES: head data.
- `pull_strobe_o` out DATA_BYTES: head byte enables.
- `fwd_address_i` in ADDR_WIDTH: load address.
- `fwd_data_o` out 8·DATA_BYTES: forwarded bytes; zero in lanes not hit.
- `fwd_strobe_o` out DATA_BYTES: lanes found in buffer.
- `fwd_hit_o` out 1: any lane hit. `fwd_full_o` out 1: all lanes hit.
- `drain_i` in 1: fence request, single-cycle pulse.
- `drained_o` out 1: one-cycle pulse, all pre-fence entries popped.
- `full_o`, `empty_o` out 1: occupancy status.

## Operation
- Circular FIFO: `head`, `tail` pointers (log2 DEPTH bits, wrap naturally) and `count` (log2 DEPTH + 1 bits).
- `pull_valid_o = !empty_o`. Pop on `pull_valid_o & pull_ready_i`. The head entry is never modified while present.
- Merge hit: `count ≥ 2`, youngest entry word address equals push word address, `merge_lock == 0`, `drain_i == 0`. On accept with a merge hit, lanes with strobe set are overwritten in the youngest entry; strobe is OR-ed. No allocation.
- Otherwise an accepted push allocates at `tail`.
- `push_ready_o = !full_o | merge_hit`. When full, a merge push is still accepted.
- Simultaneous push and pop: `count` is unchanged on allocate and decremented on merge. At `count == 2`, a merge into entry `head+1` is legal while the head pops.
- Forward: per lane, select the youngest valid entry whose word address matches and whose strobe bit is set; this includes the head. `fwd_*` are combinational from registered state; a same-cycle push is not visible.
- Drain FSM:
  - IDLE: on `drain_i`, go to DRAIN with `fence_cnt <= count - pop`; set `merge_lock` unless a push allocates in the same cycle.
  - DRAIN: decrement `fence_cnt` on each pop. When it reaches 0, pulse `drained_o` and return to IDLE.
  - `drain_i` while in DRAIN is ignored.
  - A drain with an empty buffer pulses `drained_o` on the next cycle.
- `merge_lock` clears on any allocation. Pushes during DRAIN are accepted normally.

## Timing
- Reset values: `count = 0`, FSM in IDLE, `empty_o = 1`, `full_o = 0`, `pull_valid_o = 0`, `push_ready_o = 1`, `drained_o = 0`, `merge_lock = 0`, `fwd_* = 0`.
- Push to pull/forward visibility: 1 cycle.
- Pop to next head visible: same edge.
- `drained_o` is asserted the cycle after the last pre-fence pop.
- Asynchronous reset mid-drain discards all entries and the fence state.
- Entry storage has no reset; only valid/count/FSM state is reset.

## Configuration
- `ST_BUF_MERGE_EN`:
  - Defined: coalescing as described above.
  - Undefined: every accepted push allocates, `push_ready_o = !full_o`, and `merge_lock` is removed.
  - Forwarding and drain are unchanged in both cases.

## Structure
- `store_unit_pkg`: `st_buf_entry_t` {word address, data, strobe}, `st_buf_drain_state_t` {IDLE, DRAIN}.
- Sub-module `store_forward_select`: per-lane youngest-match priority select over entries ordered relative to `head`.

## Test plan
- DEPTH=4: push 0x100/0xAABBCCDD/1111, then 0x200/0x11/0001 with no pop. Next cycle `pull_address_o = 0x100`, `pull_data_o = 0xAABBCCDD`. Two pops drain both entries in order, then `empty_o = 1`.
- Merge: entries 0x100, 0x200/0x11/0001; push 0x202/0x22<<16/0100 → count stays 2, entry 2 data 0x00220011, strobe 0101.
- Full with merge: 4 entries, tail word 0x300; push 0x301 is accepted with `full_o` held at 1; push 0x400 stalls (`push_ready_o = 0`).
- Forward: entries 0x100/0x000000FF/0001 (older) and 0x100/0x0000EE00/0010 (younger, non-mergeable after a drain) → `fwd_address_i = 0x100` gives `fwd_strobe_o = 0011`, `fwd_data_o = 0x0000EEFF`, `fwd_full_o = 0`.
- Drain: 3 entries, `drain_i` pulse, then push 0x100 matching the tail → allocates a new entry (locked). `drained_o` pulses exactly 1 cycle after the 3rd pop.
- Reset asserted during DRAIN with 2 entries → immediately `empty_o = 1`, `drained_o = 0`, `pull_valid_o = 0`.
